// File: rtl/gesture_power_sequencer_pkg.sv
// Shared types and constants for the gesture power sequencer.
// FSM state encoding is fixed at two bits so it can be observed and compared externally.
package gesture_power_sequencer_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    OFF_ARMED = 2'd1,
    ON        = 2'd2,
    ON_ARMED  = 2'd3
  } state_e;

  localparam logic [31:0] BLINK_TICKS_DEFAULT = 32'd25000000;
  localparam int unsigned WINDOW_W            = 32;

  function automatic logic is_armed(input state_e s);
    return (s == OFF_ARMED) || (s == ON_ARMED);
  endfunction

endpackage

// File: rtl/gesture_power_sequencer_if.sv
// Signal bundle for the gesture power sequencer: gesture/force inputs and status outputs.
// master drives the requests (controller side), slave is the sequencer's view.
interface gesture_power_sequencer_if
  import gesture_power_sequencer_pkg::*;
(
  input logic clk
);

  logic                left_gesture;
  logic                right_gesture;
  logic                force_off;
  logic [WINDOW_W-1:0] countdown_time;
  logic                power_on;
  logic                armed;
  logic                armed_led;
  logic [WINDOW_W-1:0] window_remaining;
  logic                toggle_pulse;
  logic                timeout_pulse;

  modport master (
    input  clk,
    output left_gesture, right_gesture, force_off, countdown_time,
    input  power_on, armed, armed_led, window_remaining, toggle_pulse, timeout_pulse
  );

  modport slave (
    input  clk,
    input  left_gesture, right_gesture, force_off, countdown_time,
    output power_on, armed, armed_led, window_remaining, toggle_pulse, timeout_pulse
  );

endinterface

// File: rtl/gesture_power_sequencer_window_counter.sv
// Gesture window down-counter: load, decrement and expiry detection.
// Priority is clear > load > decrement; expiry flags the 1->0 step of a plain decrement.
module gesture_window_counter
  import gesture_power_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic [WINDOW_W-1:0] load_val_i,
  input  logic                dec_i,
  output logic [WINDOW_W-1:0] count_o,
  output logic                expire_o
);

  logic [WINDOW_W-1:0] count_q;

  assign count_o  = count_q;
  assign expire_o = dec_i && !clear_i && !load_i && (count_q == WINDOW_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WINDOW_W'(1);
    end
  end

endmodule

// File: rtl/gesture_power_sequencer.sv
// Two-gesture power sequencer: one hand opens a timed window, the other completes the toggle.
// Optional macro GESTURE_ARM_BLINK_EN makes armed_led blink every BLINK_TICKS cycles while armed.
module gesture_power_sequencer
  import gesture_power_sequencer_pkg::*;
#(
  parameter logic [31:0] BLINK_TICKS = BLINK_TICKS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                left_gesture,
  input  logic                right_gesture,
  input  logic                force_off,
  input  logic [WINDOW_W-1:0] countdown_time,
  output logic                power_on,
  output logic                armed,
  output logic                armed_led,
  output logic [WINDOW_W-1:0] window_remaining,
  output logic                toggle_pulse,
  output logic                timeout_pulse
);

  state_e state_q;
  logic   power_on_q;
  logic   armed_q;
  logic   toggle_q;
  logic   timeout_q;

  logic   left_only;
  logic   right_only;
  logic   arm_gesture;
  logic   complete_gesture;
  logic   arm_ok;
  logic   cnt_clear;
  logic   cnt_dec;
  logic   expire;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    left_only        = left_gesture && !right_gesture;
    right_only       = right_gesture && !left_gesture;
    arm_gesture      = 1'b0;
    complete_gesture = 1'b0;
    unique case (state_q)
      OFF, OFF_ARMED: arm_gesture = left_only;
      ON,  ON_ARMED:  arm_gesture = right_only;
      default:        arm_gesture = 1'b0;
    endcase
    if (state_q == OFF_ARMED) complete_gesture = right_only;
    if (state_q == ON_ARMED)  complete_gesture = left_only;
    // A zero-length window would expire before it could be used, so it never opens.
    arm_ok    = arm_gesture && (countdown_time != '0) && !force_off;
    cnt_clear = force_off || complete_gesture;
    cnt_dec   = is_armed(state_q);
  end

  gesture_window_counter u_window (
    .clk        (clk),
    .rst        (reset),
    .clear_i    (cnt_clear),
    .load_i     (arm_ok),
    .load_val_i (countdown_time),
    .dec_i      (cnt_dec),
    .count_o    (window_remaining),
    .expire_o   (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= OFF;
      power_on_q <= 1'b0;
      armed_q    <= 1'b0;
      toggle_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      toggle_q  <= 1'b0;
      timeout_q <= 1'b0;
      if (force_off) begin
        state_q    <= OFF;
        power_on_q <= 1'b0;
        armed_q    <= 1'b0;
        toggle_q   <= power_on_q;
      end else begin
        unique case (state_q)
          OFF: if (arm_ok) begin
            state_q <= OFF_ARMED;
            armed_q <= 1'b1;
          end
          OFF_ARMED: if (complete_gesture) begin
            state_q    <= ON;
            power_on_q <= 1'b1;
            armed_q    <= 1'b0;
            toggle_q   <= 1'b1;
          end else if (expire) begin
            state_q   <= OFF;
            armed_q   <= 1'b0;
            timeout_q <= 1'b1;
          end
          ON: if (arm_ok) begin
            state_q <= ON_ARMED;
            armed_q <= 1'b1;
          end
          ON_ARMED: if (complete_gesture) begin
            state_q    <= OFF;
            power_on_q <= 1'b0;
            armed_q    <= 1'b0;
            toggle_q   <= 1'b1;
          end else if (expire) begin
            state_q   <= ON;
            armed_q   <= 1'b0;
            timeout_q <= 1'b1;
          end
          default: begin
            state_q    <= OFF;
            power_on_q <= 1'b0;
            armed_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign power_on      = power_on_q;
  assign armed         = armed_q;
  assign toggle_pulse  = toggle_q;
  assign timeout_pulse = timeout_q;

`ifdef GESTURE_ARM_BLINK_EN
  logic        armed_next;
  logic        led_q;
  logic [31:0] blink_cnt_q;

  // Mirrors the FSM's armed decision so the LED phase restarts on the arming edge.
  assign armed_next = !force_off &&
                      ((!is_armed(state_q) && arm_ok) ||
                       ( is_armed(state_q) && !complete_gesture && !expire));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q       <= 1'b0;
      blink_cnt_q <= '0;
    end else if (!armed_next) begin
      led_q       <= 1'b0;
      blink_cnt_q <= '0;
    end else if (!armed_q) begin
      led_q       <= 1'b1;
      blink_cnt_q <= '0;
    end else if (blink_cnt_q >= BLINK_TICKS - 32'd1) begin
      led_q       <= !led_q;
      blink_cnt_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_q + 32'd1;
    end
  end

  assign armed_led = led_q;
`else
  assign armed_led = armed_q;
`endif

endmodule

// File: doc/gesture_power_sequencer.md
GESTURE_POWER_SEQUENCER -- requirements
Module: gesture_power_sequencer

Interface
REQ-001 SHALL have parameter BLINK_TICKS, default 32'd25000000, clock cycles per armed-LED blink half-period.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port left_gesture  input  1  debounced single-cycle left-hand gesture pulse.
REQ-005 SHALL have port right_gesture  input  1  debounced single-cycle right-hand gesture pulse.
REQ-006 SHALL have port force_off  input  1  level; hard power-off request.
REQ-007 SHALL have port countdown_time  input  32  gesture window length in clock cycles, from the gesture timer configuration block.
REQ-008 SHALL have port power_on  output  1  current power state.
REQ-009 SHALL have port armed  output  1  high while a gesture window is open.
REQ-010 SHALL have port armed_led  output  1  user indication of an open window.
REQ-011 SHALL have port window_remaining  output  32  cycles left in the open window, 0 when idle.
REQ-012 SHALL have port toggle_pulse  output  1  one-cycle pulse on every power_on change.
REQ-013 SHALL have port timeout_pulse  output  1  one-cycle pulse when a window expires unused.

Function
REQ-014 SHALL implement FSM states OFF, OFF_ARMED, ON, ON_ARMED.
REQ-015 OFF: left_gesture alone -> OFF_ARMED, window_remaining loads countdown_time.
REQ-016 OFF_ARMED: right_gesture alone with window_remaining>=1 -> ON, power_on=1, toggle_pulse=1, window_remaining=0.
REQ-017 ON: right_gesture alone -> ON_ARMED, window_remaining loads countdown_time.
REQ-018 ON_ARMED: left_gesture alone with window_remaining>=1 -> OFF, power_on=0, toggle_pulse=1, window_remaining=0.
REQ-019 Armed states: the arming gesture repeated reloads window_remaining from countdown_time; state unchanged.
REQ-020 Armed states: window_remaining decrements by 1 each cycle with no completing gesture; the transition 1->0 returns to OFF/ON respectively with timeout_pulse=1.
REQ-021 Completing gesture in the cycle window_remaining==1 SHALL win over timeout (no timeout_pulse).
REQ-022 left_gesture and right_gesture both high in one cycle SHALL be ignored in every state (decrement still occurs).
REQ-023 Arming with countdown_time==0 SHALL be rejected; state stays OFF/ON.
REQ-024 countdown_time SHALL be sampled only at arm/reload; later changes do not affect an open window.
REQ-025 force_off high SHALL move any state to OFF next cycle, window_remaining=0, toggle_pulse=1 only if power_on was 1; overrides gestures.
REQ-026 armed SHALL be 1 exactly in OFF_ARMED/ON_ARMED; all outputs registered, one-cycle latency from input.

Reset
REQ-027 reset high SHALL immediately force OFF, power_on=0, armed=0, armed_led=0, window_remaining=0, toggle_pulse=0, timeout_pulse=0, blink counter=0, including mid-window.

Configuration
REQ-028 With GESTURE_ARM_BLINK_EN defined, armed_led SHALL toggle every BLINK_TICKS cycles while armed, starting 1 at arm, 0 when idle.
REQ-029 Without GESTURE_ARM_BLINK_EN, armed_led SHALL equal armed and no blink counter SHALL exist.

Structure
REQ-030 Shared package SHALL hold the FSM state typedef (2-bit encoding OFF=0, OFF_ARMED=1, ON=2, ON_ARMED=3) and the default BLINK_TICKS constant.
REQ-031 One sub-module, gesture_window_counter (load/decrement/expiry), SHALL be instantiated; FSM stays in the top.

Verification
REQ-032 countdown_time=10; left at t0, right at t0+5 -> power_on=1 at t0+6, single toggle_pulse, no timeout_pulse.
REQ-033 countdown_time=10; left, no right -> timeout_pulse exactly once 10 cycles after arm, state OFF, power_on=0.
REQ-034 power_on=1, countdown_time=4; right then left on the cycle window_remaining==1 -> power_on=0, no timeout_pulse.
REQ-035 Left+right same cycle in OFF; countdown_time=0 then left -> no state change, armed stays 0.
REQ-036 Armed with window_remaining=7, reset pulse -> all outputs 0 asynchronously; force_off while ON_ARMED -> OFF, one toggle_pulse.
REQ-037 With GESTURE_ARM_BLINK_EN, BLINK_TICKS=3, countdown_time=20 -> armed_led toggles every 3 cycles while armed, 0 after timeout.
